peripheral_dbg_soc_ring_ext_link: RTL and testbench



---
 rtl/peripheral_dbg_soc_dii_channel_pkg.sv | 10 +
 rtl/peripheral_dbg_soc_dii_packet_fifo.sv | 103 ++++++++++
 rtl/peripheral_dbg_soc_ring_ext_link.sv | 35 +++
 tb/tb_peripheral_dbg_soc_ring_ext_link.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_dbg_soc_dii_channel_pkg.sv
// Debug-interconnect flit type shared by every ring segment and link.
package peripheral_dbg_soc_dii_channel;

   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;

endpackage

// File: rtl/peripheral_dbg_soc_dii_packet_fifo.sv
// One link channel: registered flit FIFO whose output can be held back
// until a whole packet (or a full buffer) is stored.
module peripheral_dbg_soc_dii_packet_fifo
   import peripheral_dbg_soc_dii_channel::*;
#(
   parameter int unsigned BUFFER_SIZE = 4,
   parameter bit          FULLPACKET  = 1'b1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  dii_flit                             wr_flit,
   output logic                                wr_ready,
   output dii_flit                             rd_flit,
   input  logic                                rd_ready,
   output logic [$clog2(BUFFER_SIZE+1)-1:0]    occupancy,
   output logic [$clog2(BUFFER_SIZE+1)-1:0]    pkt_count
);

   localparam int unsigned PW = $clog2(BUFFER_SIZE);
   localparam int unsigned OW = $clog2(BUFFER_SIZE + 1);

   typedef logic [OW-1:0] cnt_t;
   typedef logic [PW-1:0] ptr_t;
   typedef enum logic {HOLD, DRAIN} state_t;

   localparam cnt_t CNT_ONE  = cnt_t'(1);
   localparam cnt_t CNT_FULL = cnt_t'(BUFFER_SIZE);
   localparam ptr_t PTR_ONE  = ptr_t'(1);

   logic [16:0] mem [BUFFER_SIZE];
   ptr_t        wr_ptr;
   ptr_t        rd_ptr;
   state_t      state;

   logic        full;
   logic        empty;
   logic        rd_valid;
   logic        head_last;
   logic        push;
   logic        pop;

   assign full      = (occupancy == CNT_FULL);
   assign empty     = (occupancy == '0);
   assign head_last = mem[rd_ptr][16];
   assign wr_ready  = rst & ~full;
   assign push      = wr_flit.valid & wr_ready;
   assign pop       = rd_valid & rd_ready;

   // In HOLD, a full buffer without a complete packet still releases so
   // packets longer than the buffer can make progress.
   always_comb begin
      rd_valid = 1'b0;
      if (rst) begin
         if (FULLPACKET && state == HOLD)
            rd_valid = (pkt_count != '0) || full;
         else
            rd_valid = ~empty;
      end
   end

   always_comb begin
      rd_flit       = '0;
      rd_flit.valid = rd_valid;
      rd_flit.last  = head_last;
      rd_flit.data  = mem[rd_ptr][15:0];
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {wr_flit.last, wr_flit.data};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         pkt_count <= '0;
         state     <= HOLD;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;

         case ({push, pop})
            2'b10:   occupancy <= occupancy + CNT_ONE;
            2'b01:   occupancy <= occupancy - CNT_ONE;
            default: occupancy <= occupancy;
         endcase

         case ({push & wr_flit.last, pop & head_last})
            2'b10:   pkt_count <= pkt_count + CNT_ONE;
            2'b01:   pkt_count <= pkt_count - CNT_ONE;
            default: pkt_count <= pkt_count;
         endcase

         if (pop)
            state <= head_last ? HOLD : DRAIN;
      end
   end

endmodule

// File: rtl/peripheral_dbg_soc_ring_ext_link.sv
// Buffered two-channel link between the extension ports of adjacent
// debug ring segments; one packet FIFO per ring channel.
module peripheral_dbg_soc_ring_ext_link
   import peripheral_dbg_soc_dii_channel::*;
#(
   parameter int unsigned BUFFER_SIZE = 4,
   parameter bit          FULLPACKET  = 1'b1
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  dii_flit [1:0]                           ext_in,
   output logic [1:0]                              ext_in_ready,
   output dii_flit [1:0]                           ext_out,
   input  logic [1:0]                              ext_out_ready,
   output logic [1:0][$clog2(BUFFER_SIZE+1)-1:0]   occupancy,
   output logic [1:0][$clog2(BUFFER_SIZE+1)-1:0]   pkt_count
);

   for (genvar c = 0; c < 2; c++) begin : g_ch
      peripheral_dbg_soc_dii_packet_fifo #(
         .BUFFER_SIZE (BUFFER_SIZE),
         .FULLPACKET  (FULLPACKET)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .wr_flit   (ext_in[c]),
         .wr_ready  (ext_in_ready[c]),
         .rd_flit   (ext_out[c]),
         .rd_ready  (ext_out_ready[c]),
         .occupancy (occupancy[c]),
         .pkt_count (pkt_count[c])
      );
   end

endmodule

// File: tb/tb_peripheral_dbg_soc_ring_ext_link.sv
// Directed bench: one link with packet holding, one as a plain FIFO.
module tb_peripheral_dbg_soc_ring_ext_link;
   import peripheral_dbg_soc_dii_channel::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dii_flit [1:0]     in_a, out_a, in_b, out_b;
   logic [1:0]        ir_a, or_a, ir_b, or_b;
   logic [1:0][2:0]   occ_a, pc_a, occ_b, pc_b;

   int tests = 0;
   int fails = 0;

   peripheral_dbg_soc_ring_ext_link #(.BUFFER_SIZE(4), .FULLPACKET(1'b1)) dut_a (
      .clk(clk), .rst(rst), .ext_in(in_a), .ext_in_ready(ir_a), .ext_out(out_a),
      .ext_out_ready(or_a), .occupancy(occ_a), .pkt_count(pc_a));

   peripheral_dbg_soc_ring_ext_link #(.BUFFER_SIZE(4), .FULLPACKET(1'b0)) dut_b (
      .clk(clk), .rst(rst), .ext_in(in_b), .ext_in_ready(ir_b), .ext_out(out_b),
      .ext_out_ready(or_b), .occupancy(occ_b), .pkt_count(pc_b));

   function automatic dii_flit mk(input logic v, input logic l, input logic [15:0] d);
      dii_flit f;
      f.valid = v;
      f.last  = l;
      f.data  = d;
      return f;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Streams n flits into link A channel 0 and checks they leave in order.
   task automatic stream_a0(input string tag, input logic [15:0] base, input int n, input bit single);
      int si = 0;
      int ri = 0;
      int cyc = 0;
      while (ri < n && cyc < 60) begin
         in_a[0] = (si < n) ? mk(1'b1, single || si == n - 1, 16'(base + si)) : mk(1'b0, 1'b0, 16'h0);
         if (out_a[0].valid && or_a[0]) begin
            chk({tag, "_data"}, out_a[0].data, 16'(base + ri));
            chk({tag, "_last"}, out_a[0].last, single || ri == n - 1);
            ri++;
         end
         if (in_a[0].valid && ir_a[0]) si++;
         tick();
         cyc++;
      end
      in_a[0] = mk(1'b0, 1'b0, 16'h0);
      chk({tag, "_count"}, ri, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int si, ri, cyc, acc;
      logic push_now;

      // Reset while upstream drives valid flits
      in_a  = {mk(1'b1, 1'b1, 16'hAAAA), mk(1'b1, 1'b1, 16'hAAAA)};
      in_b  = {mk(1'b1, 1'b1, 16'hBBBB), mk(1'b1, 1'b1, 16'hBBBB)};
      or_a  = 2'b11;
      or_b  = 2'b11;
      rst   = 1'b0;
      tick(); tick(); tick();
      chk("rst_ready_a", ir_a, 2'b00);
      chk("rst_ready_b", ir_b, 2'b00);
      chk("rst_valid_a", {out_a[1].valid, out_a[0].valid}, 2'b00);
      chk("rst_valid_b", {out_b[1].valid, out_b[0].valid}, 2'b00);
      chk("rst_occ_a", occ_a, 6'd0);
      chk("rst_occ_b", occ_b, 6'd0);
      in_a = '0;
      in_b = '0;
      rst  = 1'b1;
      #1;
      chk("rel_ready_a", ir_a, 2'b11);
      chk("rel_ready_b", ir_b, 2'b11);

      // 3-flit packet held until its last flit is stored
      in_a[0] = mk(1'b1, 1'b0, 16'h1111); tick();
      chk("pk3_hold1", out_a[0].valid, 1'b0);
      in_a[0] = mk(1'b1, 1'b0, 16'h2222); tick();
      chk("pk3_hold2", out_a[0].valid, 1'b0);
      in_a[0] = mk(1'b1, 1'b1, 16'h3333); tick();
      in_a[0] = mk(1'b0, 1'b0, 16'h0);
      chk("pk3_rel_valid", out_a[0].valid, 1'b1);
      chk("pk3_d0", out_a[0].data, 16'h1111);
      chk("pk3_pc1", pc_a[0], 3'd1);
      tick();
      chk("pk3_d1", {out_a[0].valid, out_a[0].data}, {1'b1, 16'h2222});
      tick();
      chk("pk3_d2", {out_a[0].valid, out_a[0].last, out_a[0].data}, {1'b1, 1'b1, 16'h3333});
      tick();
      chk("pk3_end_valid", out_a[0].valid, 1'b0);
      chk("pk3_end_pc", pc_a[0], 3'd0);
      chk("pk3_end_occ", occ_a[0], 3'd0);

      // 6-flit packet longer than the buffer: full escape then drain
      si = 0; ri = 0; cyc = 0;
      while (ri < 6 && cyc < 40) begin
         in_a[0] = (si < 6) ? mk(1'b1, si == 5, 16'(16'h00A0 + si)) : mk(1'b0, 1'b0, 16'h0);
         if (si < 4) chk("pk6_hold", out_a[0].valid, 1'b0);
         if (si == 4 && ri == 0) begin
            chk("pk6_escape_valid", out_a[0].valid, 1'b1);
            chk("pk6_full_ready", ir_a[0], 1'b0);
            chk("pk6_full_occ", occ_a[0], 3'd4);
         end
         if (out_a[0].valid && or_a[0]) begin
            chk("pk6_data", {out_a[0].last, out_a[0].data}, {ri == 5, 16'(16'h00A0 + ri)});
            ri++;
         end
         if (in_a[0].valid && ir_a[0]) si++;
         tick();
         cyc++;
      end
      in_a[0] = mk(1'b0, 1'b0, 16'h0);
      chk("pk6_count", ri, 6);
      // back in HOLD: a lone non-last flit must not be released
      in_a[0] = mk(1'b1, 1'b0, 16'hBEEF); tick();
      chk("pk6_back_hold", out_a[0].valid, 1'b0);
      chk("pk6_back_occ", occ_a[0], 3'd1);
      in_a[0] = mk(1'b1, 1'b1, 16'hBEF0); tick();
      in_a[0] = mk(1'b0, 1'b0, 16'h0);
      chk("pk6_tail_valid", {out_a[0].valid, out_a[0].data}, {1'b1, 16'hBEEF});
      tick(); tick();
      chk("pk6_tail_occ", occ_a[0], 3'd0);

      // Plain FIFO: fill with downstream stalled, then drain
      or_b[0] = 1'b0;
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         in_b[0] = mk(1'b1, 1'b0, 16'(16'h00C0 + acc));
         if (ir_b[0]) acc++;
         tick();
      end
      chk("ff_accepts", acc, 4);
      chk("ff_full_occ", occ_b[0], 3'd4);
      chk("ff_full_ready", ir_b[0], 1'b0);
      chk("ff_valid", out_b[0].valid, 1'b1);
      or_b[0] = 1'b1;
      chk("ff_d0", out_b[0].data, 16'h00C0);
      tick();
      chk("ff_ready_rise", ir_b[0], 1'b1);
      chk("ff_occ3", occ_b[0], 3'd3);
      ri = 1; cyc = 0;
      while (ri < 5 && cyc < 20) begin
         if (out_b[0].valid && or_b[0]) begin
            chk("ff_data", out_b[0].data, 16'(16'h00C0 + ri));
            ri++;
         end
         push_now = in_b[0].valid && ir_b[0];
         tick();
         cyc++;
         if (push_now) in_b[0] = mk(1'b0, 1'b0, 16'h0);
      end
      chk("ff_count", ri, 5);
      chk("ff_end_occ", occ_b[0], 3'd0);

      // Channel independence: ch1 stalled with 2 packets, ch0 streams
      or_a[1] = 1'b0;
      in_a[1] = mk(1'b1, 1'b1, 16'h00E0); tick();
      in_a[1] = mk(1'b1, 1'b1, 16'h00E1); tick();
      in_a[1] = mk(1'b0, 1'b0, 16'h0);
      stream_a0("ind", 16'h00D0, 10, 1'b1);
      chk("ind_ch1_occ", occ_a[1], 3'd2);
      chk("ind_ch1_pc", pc_a[1], 3'd2);
      chk("ind_ch1_head", {out_a[1].valid, out_a[1].data}, {1'b1, 16'h00E0});
      chk("ind_ch0_occ", occ_a[0], 3'd0);

      // Reset in mid-packet discards the partial packet
      in_a[0] = mk(1'b1, 1'b0, 16'h00F0); tick();
      in_a[0] = mk(1'b1, 1'b0, 16'h00F1); tick();
      in_a[0] = mk(1'b0, 1'b0, 16'h0);
      chk("mid_occ", occ_a[0], 3'd2);
      chk("mid_hold", out_a[0].valid, 1'b0);
      rst = 1'b0;
      tick();
      chk("mid_rst_occ", occ_a, 6'd0);
      chk("mid_rst_pc", pc_a, 6'd0);
      chk("mid_rst_ready", ir_a, 2'b00);
      chk("mid_rst_valid", {out_a[1].valid, out_a[0].valid}, 2'b00);
      rst = 1'b1;
      or_a = 2'b11;
      #1;
      chk("mid_rel_ready", ir_a, 2'b11);
      stream_a0("post", 16'h7100, 3, 1'b0);
      chk("post_occ", occ_a[0], 3'd0);
      chk("post_pc", pc_a[0], 3'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
